// File: rtl/layer_2_input_packer.sv
// ============================================================================
//  Module   : layer_2_input_packer
//  Purpose  : Packs a channel-interleaved serial word stream into NUM_CH-lane
//             pixel beats, raster-tagged, one IMG_SIZE x IMG_SIZE frame per start.
//  Options  : LAYER_PACKER_STALL_CNT_EN adds the stall_cnt output.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_2_input_packer #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_CH     = 16,
   parameter int IMG_SIZE   = 208
) (
   input  logic                           Clk,
   input  logic                           Rst,
   input  logic                           start,
   input  logic [DATA_WIDTH-1:0]          s_data,
   input  logic                           s_valid,
   output logic                           s_ready,
   output logic [DATA_WIDTH*NUM_CH-1:0]   data_out,
   output logic                           valid_out,
   output logic                           eol_out,
   output logic                           eof_out,
   output logic                           busy,
   output logic                           frame_done
`ifdef LAYER_PACKER_STALL_CNT_EN
   ,
   output logic [31:0]                    stall_cnt
`endif
);

   localparam int CH_W = (NUM_CH   > 1) ? $clog2(NUM_CH)   : 1;
   localparam int PX_W = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
   localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
   localparam logic [PX_W-1:0] PX_LAST = PX_W'(IMG_SIZE - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]                               state_q, state_d;
   logic [CH_W-1:0]                          ch_cnt_q, ch_cnt_d;
   logic [PX_W-1:0]                          col_cnt_q, col_cnt_d;
   logic [PX_W-1:0]                          row_cnt_q, row_cnt_d;
   logic [NUM_CH-1:0][DATA_WIDTH-1:0]        lane_q, lane_d;
   logic [DATA_WIDTH*NUM_CH-1:0]             data_q, data_d;
   logic                                     valid_q, valid_d;
   logic                                     eol_q, eol_d;
   logic                                     eof_q, eof_d;
   logic                                     done_q, done_d;
   logic                                     accept;

   assign accept = (state_q == ST_RUN) && s_valid;

   always_comb begin
      state_d   = state_q;
      ch_cnt_d  = ch_cnt_q;
      col_cnt_d = col_cnt_q;
      row_cnt_d = row_cnt_q;
      lane_d    = lane_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      eol_d     = 1'b0;
      eof_d     = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_RUN;
               ch_cnt_d  = '0;
               col_cnt_d = '0;
               row_cnt_d = '0;
            end
         end
         ST_RUN: begin
            if (accept) begin
               lane_d[ch_cnt_q] = s_data;
               if (ch_cnt_q == CH_LAST) begin
                  // lane_d already carries the final word, so the beat is complete here
                  ch_cnt_d = '0;
                  data_d   = lane_d;
                  valid_d  = 1'b1;
                  if (col_cnt_q == PX_LAST) begin
                     eol_d     = 1'b1;
                     col_cnt_d = '0;
                     if (row_cnt_q == PX_LAST) begin
                        eof_d     = 1'b1;
                        row_cnt_d = '0;
                        state_d   = ST_DONE;
                     end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                     end
                  end else begin
                     col_cnt_d = col_cnt_q + 1'b1;
                  end
               end else begin
                  ch_cnt_d = ch_cnt_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q   <= ST_IDLE;
         ch_cnt_q  <= '0;
         col_cnt_q <= '0;
         row_cnt_q <= '0;
         lane_q    <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         eol_q     <= 1'b0;
         eof_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ch_cnt_q  <= ch_cnt_d;
         col_cnt_q <= col_cnt_d;
         row_cnt_q <= row_cnt_d;
         lane_q    <= lane_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         eol_q     <= eol_d;
         eof_q     <= eof_d;
         done_q    <= done_d;
      end
   end

`ifdef LAYER_PACKER_STALL_CNT_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((state_q == ST_IDLE) && start) begin
         stall_d = '0;
      end else if ((state_q == ST_RUN) && !s_valid && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt = stall_q;
`endif

   assign s_ready    = (state_q == ST_RUN);
   assign busy       = (state_q == ST_RUN);
   assign data_out   = data_q;
   assign valid_out  = valid_q;
   assign eol_out    = eol_q;
   assign eof_out    = eof_q;
   assign frame_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_layer_2_input_packer.sv
// ============================================================================
//  Module   : tb_layer_2_input_packer
//  Purpose  : Directed self-checking bench for layer_2_input_packer (IMG_SIZE=4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_layer_2_input_packer;

   localparam int DW   = 32;
   localparam int NCH  = 16;
   localparam int IMG  = 4;
   localparam int NPIX = IMG * IMG;
   localparam int BW   = DW * NCH;

   localparam logic [DW-1:0] BASE_A = 32'h3C00_0000;
   localparam logic [DW-1:0] BASE_C = 32'h5000_0000;
   localparam logic [DW-1:0] BASE_D = 32'h6000_0000;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          start;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic [BW-1:0] data_out;
   logic          valid_out;
   logic          eol_out;
   logic          eof_out;
   logic          busy;
   logic          frame_done;
`ifdef LAYER_PACKER_STALL_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   layer_2_input_packer #(
      .DATA_WIDTH (DW),
      .NUM_CH     (NCH),
      .IMG_SIZE   (IMG)
   ) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .start      (start),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .eol_out    (eol_out),
      .eof_out    (eof_out),
      .busy       (busy),
      .frame_done (frame_done)
`ifdef LAYER_PACKER_STALL_CNT_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   always #5 Clk = ~Clk;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   // Capture every emitted pixel and frame_done pulse
   logic [BW-1:0] cap_data [0:63];
   logic          cap_eol  [0:63];
   logic          cap_eof  [0:63];
   int            cap_cyc  [0:63];
   int            pix_n  = 0;
   int            fd_n   = 0;
   int            fd_cyc = 0;

   always @(negedge Clk) begin
      if (valid_out) begin
         if (pix_n < 64) begin
            cap_data[pix_n] = data_out;
            cap_eol[pix_n]  = eol_out;
            cap_eof[pix_n]  = eof_out;
            cap_cyc[pix_n]  = cyc;
         end
         pix_n = pix_n + 1;
      end
      if (frame_done) begin
         fd_n   = fd_n + 1;
         fd_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] w);
      s_data  = w;
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
   endtask

   function automatic logic [DW-1:0] word(input logic [DW-1:0] base, input int p, input int k);
      return base + DW'(p * 256 + k);
   endfunction

   function automatic logic [BW-1:0] pix(input logic [DW-1:0] base, input int p);
      logic [BW-1:0] r;
      r = '0;
      for (int k = 0; k < NCH; k++) r[k*DW +: DW] = word(base, p, k);
      return r;
   endfunction

   initial begin
      int base;
      int acc0;
      int gaps;

      // Reset with s_valid asserted
      Rst = 1'b1; start = 1'b0; s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
      tick(); tick();
      @(negedge Clk);
      chk("rst_s_ready",    BW'(s_ready),    BW'(1'b0));
      chk("rst_valid_out",  BW'(valid_out),  BW'(1'b0));
      chk("rst_data_out",   data_out,        '0);
      chk("rst_busy",       BW'(busy),       BW'(1'b0));
      chk("rst_eol_eof_fd", BW'({eol_out, eof_out, frame_done}), BW'(3'b000));
      Rst = 1'b0;
      tick(); tick();
      @(negedge Clk);
      chk("idle_s_ready", BW'(s_ready), BW'(1'b0));
      chk("idle_no_pix",  BW'(pix_n),   BW'(0));
      s_valid = 1'b0;

      // Continuous frame, with start pulsed during RUN and in DONE
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("run_busy",    BW'(busy),    BW'(1'b1));
      chk("run_s_ready", BW'(s_ready), BW'(1'b1));
      base = pix_n;
      acc0 = 0;
      for (int p = 0; p < NPIX; p++) begin
         for (int k = 0; k < NCH; k++) begin
            if (p == 5 && k == 3) start = 1'b1;
            send(word(BASE_A, p, k));
            start = 1'b0;
            if (p == 0 && k == NCH - 1) acc0 = cyc;
         end
      end
      start = 1'b1; s_valid = 1'b1; s_data = 32'hBAD0_BAD0;
      tick();
      start = 1'b0; s_valid = 1'b0;
      tick(); tick();
      chk("f1_pix_count",  BW'(pix_n - base), BW'(NPIX));
      chk("f1_latency",    BW'(cap_cyc[base]), BW'(acc0));
      for (int i = 0; i < NPIX; i++) begin
         chk($sformatf("f1_data%0d", i), cap_data[base + i], pix(BASE_A, i));
         chk($sformatf("f1_eol%0d", i),  BW'(cap_eol[base + i]), BW'((i % IMG) == IMG - 1));
         chk($sformatf("f1_eof%0d", i),  BW'(cap_eof[base + i]), BW'(i == NPIX - 1));
      end
      for (int i = 1; i < NPIX; i++)
         chk($sformatf("f1_spacing%0d", i), BW'(cap_cyc[base + i] - cap_cyc[base + i - 1]), BW'(NCH));
      chk("f1_fd_count",   BW'(fd_n), BW'(1));
      chk("f1_fd_timing",  BW'(fd_cyc), BW'(cap_cyc[base + NPIX - 1] + 1));
      chk("f1_busy_after", BW'(busy), BW'(1'b0));
      chk("f1_ready_after", BW'(s_ready), BW'(1'b0));
      chk("f1_data_hold",  data_out, pix(BASE_A, NPIX - 1));

      // Gapped frame must reproduce the same pixels
      start = 1'b1;
      tick();
      start = 1'b0;
      base = pix_n;
      gaps = 0;
      for (int idx = 0; idx < NPIX * NCH; idx++) begin
         if (idx > 0 && $urandom_range(0, 1) == 1) begin
            tick();
            gaps++;
         end
         send(word(BASE_A, idx / NCH, idx % NCH));
      end
      tick(); tick(); tick();
      chk("g_pix_count", BW'(pix_n - base), BW'(NPIX));
      for (int i = 0; i < NPIX; i++)
         chk($sformatf("g_data%0d", i), cap_data[base + i], pix(BASE_A, i));
      chk("g_eof_last", BW'(cap_eof[base + NPIX - 1]), BW'(1'b1));
      chk("g_fd_count", BW'(fd_n), BW'(2));
`ifdef LAYER_PACKER_STALL_CNT_EN
      chk("g_stall_cnt", BW'(stall_cnt), BW'(gaps));
`endif

      // Mid-frame reset drops the partial pixel
      start = 1'b1;
      tick();
      start = 1'b0;
      base = pix_n;
      for (int k = 0; k < NCH; k++) send(word(BASE_C, 0, k));
      for (int k = 0; k < 8; k++)   send(word(BASE_C, 1, k));
      Rst = 1'b1;
      tick(); tick();
      Rst = 1'b0;
      tick(); tick();
      chk("mr_pix_count", BW'(pix_n - base), BW'(1));
      chk("mr_data_pix0", cap_data[base], pix(BASE_C, 0));
      chk("mr_data_clr",  data_out, '0);
      chk("mr_busy",      BW'(busy), BW'(1'b0));
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < NCH; k++) send(word(BASE_D, 0, k));
      tick();
      chk("mr2_pix_count", BW'(pix_n - base), BW'(2));
      chk("mr2_data",      cap_data[base + 1], pix(BASE_D, 0));
      chk("mr2_eol",       BW'(cap_eol[base + 1]), BW'(1'b0));
      chk("mr2_eof",       BW'(cap_eof[base + 1]), BW'(1'b0));
      chk("mr2_fd_count",  BW'(fd_n), BW'(2));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

`default_nettype wire
